ret_addr_stack: RTL
===================

# ret_addr_stack

Hardware return-address stack for the multi-cycle CPU. The control unit pushes the return address (PC + 1) on a subroutine call and pops it on return. The popped address is registered and driven to the program counter's load input, so a return loads the PC without a memory access. The stack is a circular LIFO that overwrites its oldest entry when full and reports misuse through sticky error flags.

## Interface
- ADDR_W, 13, address width; matches the PC width.
- DEPTH, 8, number of entries; power of two, at least 2.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  store pushData on top of the stack this cycle.
- pop  in  1  remove the top entry and present it on popData next cycle.
- pushData  in  ADDR_W  return address to store.
- popData  out  ADDR_W  registered last-popped address; feeds the PC load data.
- popValid  out  1  one-cycle pulse; popData was updated by the accepted pop of the previous cycle.
- count  out  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH.
- empty  out  1  count == 0 (combinational from count).
- full  out  1  count == DEPTH (combinational from count).
- overflow  out  1  sticky; a push occurred while full.
- underflow  out  1  sticky; a pop occurred while empty without a simultaneous push.
- clrErr  in  1  synchronous clear of overflow and underflow.

## Operation
- Storage: DEPTH x ADDR_W register array. Storage is not reset.
- sp: log2(DEPTH)-bit pointer to the next free slot. It wraps modulo DEPTH. The top entry is mem[sp-1] (mod DEPTH).
- Reset values: sp=0, count=0, popData=0, popValid=0, overflow=0, underflow=0. Therefore empty=1 and full=0.
- Push only:
  - mem[sp] <= pushData; sp <= sp+1.
  - If not full: count <= count+1.
  - If full: count stays at DEPTH, the oldest entry is silently overwritten, and overflow <= 1.
- Pop only:
  - If not empty: popData <= mem[sp-1]; sp <= sp-1; count <= count-1; popValid <= 1 next cycle.
  - If empty: no state change except underflow <= 1. popData holds its value and popValid stays 0.
- Push and pop in the same cycle (replace-top):
  - If not empty: popData <= mem[sp-1]; mem[sp-1] <= pushData; sp and count unchanged; popValid pulses.
  - If empty: bypass, popData <= pushData; popValid pulses; sp, count and memory unchanged; no error flag.
- Neither push nor pop: popValid <= 0; all other state holds.
- clrErr clears both sticky flags. If a new error event occurs in the same cycle as clrErr, the set wins.
- Overflow never corrupts the newest DEPTH entries. After K > DEPTH pushes, the pops return the last DEPTH pushed values in reverse order, then the stack reports empty.

## Timing
- Push latency: the entry is visible to a pop issued in the following cycle. Back-to-back push then pop returns the pushed value.
- Pop latency: popData and popValid are valid one cycle after the pop cycle. popData holds until the next accepted pop.
- count, empty and full reflect the previous edge's operation; they are valid in the same cycle the control unit samples them.
- Throughput: one operation, or one replace-top, per cycle with no stalls.
- Asynchronous reset mid-operation: all outputs go to their reset values immediately. A pop in flight is dropped and popValid is forced to 0.

## Test plan
- Reset and idle: assert rst mid-cycle -> immediately count=0, empty=1, full=0, popValid=0, popData=0, flags 0.
- LIFO order (DEPTH=8): push 0x0010, 0x0020, 0x0030; then pop 3 times -> popData 0x0030, 0x0020, 0x0010 on consecutive cycles, each with popValid=1; then empty=1.
- Wrap and overflow (DEPTH=8): push 0x0001..0x000A (10 values) -> full=1, count=8, overflow=1. Pop 8 times -> popData 0x000A down to 0x0003; then empty=1. A 9th pop -> underflow=1, popValid=0, popData stays 0x0003.
- Replace-top: push 0x1ABC; then push=pop=1 with pushData 0x0005 -> popData=0x1ABC, count=1. Next pop -> popData=0x0005.
- Empty bypass: empty stack, push=pop=1 with pushData 0x0777 -> next cycle popData=0x0777, popValid=1, count=0, underflow=0.
- Error clear priority: set underflow; in one cycle assert clrErr together with a pop on empty -> underflow stays 1. Assert clrErr alone -> both flags 0.

Source files
------------

// File: rtl/ret_addr_stack.sv
// ret_addr_stack: circular LIFO of return addresses for the multi-cycle CPU.
// A call pushes PC+1, a return pops it into a registered popData that feeds
// the PC load input. When full, a push overwrites the oldest entry. Misuse is
// reported through sticky overflow/underflow flags.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, pushData  store pushData on top of the stack
//   pop             pop top entry; popData/popValid valid next cycle
//   clrErr          synchronous clear of the sticky error flags
//   popData         last popped address (registered)
//   popValid        one-cycle pulse after an accepted pop
//   count           number of valid entries, 0..DEPTH
//   empty, full     decoded from count
//   overflow        sticky: push while full
//   underflow       sticky: pop while empty without a simultaneous push
module ret_addr_stack #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          pushData,
    input  logic                       clrErr,
    output logic [ADDR_W-1:0]          popData,
    output logic                       popValid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  sp_q, sp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] pop_data_q, pop_data_d;
    logic              pop_valid_q, pop_valid_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              mem_we;
    logic [PTR_W-1:0]  mem_waddr;
    logic [PTR_W-1:0]  top;

    // Top of stack sits one below the free-slot pointer, modulo DEPTH.
    assign top   = PTR_W'(sp_q - 1'b1);
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));

    // Next-state decode for pointer, count, pop register and error flags.
    always_comb begin
        sp_d        = sp_q;
        cnt_d       = cnt_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        ovf_d       = ovf_q & ~clrErr;
        unf_d       = unf_q & ~clrErr;
        mem_we      = 1'b0;
        mem_waddr   = sp_q;

        unique case ({push, pop})
            2'b10: begin
                mem_we = 1'b1;
                sp_d   = PTR_W'(sp_q + 1'b1);
                if (full) begin
                    // Pointer wraps onto the oldest entry; count saturates.
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            2'b01: begin
                if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    pop_data_d  = mem_q[top];
                    pop_valid_d = 1'b1;
                    sp_d        = top;
                    cnt_d       = CNT_W'(cnt_q - 1'b1);
                end
            end
            2'b11: begin
                pop_valid_d = 1'b1;
                if (empty) begin
                    // Bypass: the pushed address is returned straight away.
                    pop_data_d = pushData;
                end else begin
                    pop_data_d = mem_q[top];
                    mem_we     = 1'b1;
                    mem_waddr  = top;
                end
            end
            default: ;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q        <= '0;
            cnt_q       <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            cnt_q       <= cnt_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // Entry storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= pushData;
        end
    end

    assign popData   = pop_data_q;
    assign popValid  = pop_valid_q;
    assign count     = cnt_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
